nco_sweep_ctrl: RTL and testbench
=================================

Name: nco_sweep_ctrl

Overview:
Sweep controller that generates the phase-increment (step) word for the NCO. It walks the frequency linearly from a start word to a stop word in fixed increments and holds each value for a programmable number of clock cycles. It supports single-shot and continuous (repeating) sweeps. It sits directly upstream of the NCO, and its step output connects straight to the NCO step input.

Parameters:
STEP_SIZE, 16, width of frequency/step words (must match NCO STEP_SIZE)
DWELL_WIDTH, 16, width of dwell counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a sweep; ignored while busy
abort  input  1  terminate the sweep in progress; wins over start in the same cycle
continuous  input  1  sampled at start: 1 = restart from f_start after each sweep, 0 = single sweep
f_start  input  STEP_SIZE  first step word, sampled at start
f_stop  input  STEP_SIZE  final step word, sampled at start
f_inc  input  STEP_SIZE  increment per dwell, sampled at start
dwell  input  DWELL_WIDTH  extra cycles per frequency, sampled at start; each value is held dwell+1 cycles
step  output  STEP_SIZE  step word to the NCO, registered
busy  output  1  high while a sweep is active
done  output  1  one-cycle pulse when a single-shot sweep completes

Behaviour:
- Reset (async, active-high): state=IDLE, step=0, busy=0, done=0, dwell counter=0, all config registers=0.
- States:
  - IDLE: step holds its last value, busy=0.
  - RUN: dwell counter active.
  - DONE: one cycle, done=1.
- IDLE -> RUN:
  - Triggered by start=1 and abort=0 at edge n.
  - At edge n: latch f_start/f_stop/f_inc/dwell/continuous, step<=f_start, cnt<=dwell, busy<=1.
  - From edge n, step==f_start and busy==1 (one-cycle latency).
- RUN, cnt!=0: cnt<=cnt-1, step holds.
- RUN, cnt==0 (end of dwell):
  - End-of-sweep condition: step==f_stop, OR f_inc==0, OR latched f_start>=f_stop.
  - If not end of sweep:
    - nxt = step + f_inc, computed STEP_SIZE+1 wide.
    - step <= (carry or nxt>f_stop) ? f_stop : nxt[STEP_SIZE-1:0].
    - cnt <= dwell.
  - If end of sweep and continuous=1: step<=f_start, cnt<=dwell, stay in RUN with no gap cycle.
  - If end of sweep and continuous=0: go to DONE, busy<=0, done<=1, step holds the final value.
- DONE -> IDLE unconditionally next edge; done<=0.
  - A start arriving while in DONE is ignored.
- Degenerate cases:
  - f_stop is always reached exactly; the sweep never overshoots.
  - f_inc=0 or f_start>=f_stop: single-frequency sweep of dwell+1 cycles at f_start, then end (or repeat if continuous).
- abort=1 in RUN or DONE: next edge state=IDLE, busy=0, done=0, step holds its current value. abort in IDLE has no effect.
- start while busy: ignored. Config inputs are only sampled at an accepted start; changes during a sweep have no effect.
- Reset mid-sweep: immediate return to reset values regardless of state.
- Wrap-around: the dwell counter never wraps (it reloads at 0). The step adder saturates to f_stop on carry.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - default STEP_SIZE shared with the NCO.
- No sub-module is required. The optional natural split is a dwell_counter (load/decrement/zero flag). Top-level integration wires step into NCO.step with a shared clk.

Test Plan:
- Basic single sweep: f_start=100, f_stop=130, f_inc=10, dwell=2, continuous=0, start pulse -> step=100,110,120,130 each for 3 cycles; done=1 exactly one cycle after the last 130 cycle; busy high for 12 cycles; step stays 130 in IDLE.
- Saturation: f_start=100, f_stop=125, f_inc=10, dwell=0 -> step=100,110,120,125, then done. Also f_start=16'hFFF0, f_stop=16'hFFFF, f_inc=16'h0020 -> 16'hFFF0 then 16'hFFFF with no wrap to a small value.
- Continuous: f_start=0, f_stop=20, f_inc=10, dwell=1, continuous=1 -> repeating 0,0,10,10,20,20,0,0,..., busy stays 1, done never asserts; abort -> busy=0 next cycle, step frozen, done=0.
- Degenerate: f_inc=0, f_start=50, dwell=3 -> step=50 for 4 cycles, then done pulse. Repeat with f_start=200, f_stop=100 -> same result at step=200.
- Start/abort interplay:
  - start while busy -> no restart, sequence unchanged;
  - start and abort in the same IDLE cycle -> stays IDLE, step unchanged;
  - config inputs changed mid-sweep -> no effect.
- Async reset mid-sweep: assert rst between clock edges during RUN -> step=0, busy=0, done=0 immediately with no clock edge; after release, a new start runs normally.

Source files
------------

// File: rtl/nco_sweep_ctrl_pkg.sv
// Shared definitions for the NCO sweep controller.
//   - state_t           : sweep FSM state encoding
//   - STEP_SIZE_DEFAULT : default step-word width, shared with the NCO
package nco_sweep_ctrl_pkg;

    localparam int STEP_SIZE_DEFAULT  = 16;
    localparam int DWELL_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nco_sweep_ctrl_dwell_counter.sv
// Dwell counter for the sweep controller.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset (count clears to 0)
//   load        : load load_value (has priority over dec)
//   load_value  : value to load
//   dec         : decrement by one. The counter saturates at zero and never wraps.
//   count_zero  : high when the count is zero
module nco_sweep_ctrl_dwell_counter #(
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [DWELL_WIDTH-1:0] load_value,
    input  logic                   dec,
    output logic                   count_zero
);

    logic [DWELL_WIDTH-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign count_zero = (count_reg == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Linear frequency sweep controller feeding the NCO step input.
// Walks the step word from f_start to f_stop in f_inc increments. Each value is
// held for dwell+1 cycles. The sweep runs once or repeats continuously.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start, abort      : begin a sweep (ignored while busy) / terminate a sweep
//                       (abort wins over start)
//   continuous        : repeat the sweep. Sampled at start.
//   f_start, f_stop, f_inc, dwell : sweep configuration. Sampled at start.
//   step              : registered step word to the NCO
//   busy              : a sweep is active
//   done              : one-cycle pulse at the end of a single-shot sweep
module nco_sweep_ctrl
    import nco_sweep_ctrl_pkg::*;
#(
    parameter int STEP_SIZE   = STEP_SIZE_DEFAULT,
    parameter int DWELL_WIDTH = DWELL_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   continuous,
    input  logic [STEP_SIZE-1:0]   f_start,
    input  logic [STEP_SIZE-1:0]   f_stop,
    input  logic [STEP_SIZE-1:0]   f_inc,
    input  logic [DWELL_WIDTH-1:0] dwell,
    output logic [STEP_SIZE-1:0]   step,
    output logic                   busy,
    output logic                   done
);

    state_t                 state_reg, state_next;
    logic [STEP_SIZE-1:0]   step_reg, step_next;
    logic [STEP_SIZE-1:0]   f_start_reg, f_stop_reg, f_inc_reg;
    logic [DWELL_WIDTH-1:0] dwell_reg;
    logic                   continuous_reg;
    logic                   cfg_load;

    logic                   cnt_load, cnt_dec, cnt_zero;
    logic [DWELL_WIDTH-1:0] cnt_load_value;

    // The extra bit catches adder carry, so that a wrap saturates to f_stop.
    logic [STEP_SIZE:0]     step_sum;
    logic                   step_saturate;
    logic                   sweep_end;

    assign step_sum      = {1'b0, step_reg} + {1'b0, f_inc_reg};
    assign step_saturate = step_sum[STEP_SIZE] || (step_sum[STEP_SIZE-1:0] > f_stop_reg);
    // A zero increment or an empty/inverted range collapses to a single
    // frequency at f_start.
    assign sweep_end     = (step_reg == f_stop_reg) || (f_inc_reg == '0) ||
                           (f_start_reg >= f_stop_reg);

    nco_sweep_ctrl_dwell_counter #(
        .DWELL_WIDTH (DWELL_WIDTH)
    ) u_dwell_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .dec        (cnt_dec),
        .count_zero (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            step_reg       <= '0;
            f_start_reg    <= '0;
            f_stop_reg     <= '0;
            f_inc_reg      <= '0;
            dwell_reg      <= '0;
            continuous_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            if (cfg_load) begin
                f_start_reg    <= f_start;
                f_stop_reg     <= f_stop;
                f_inc_reg      <= f_inc;
                dwell_reg      <= dwell;
                continuous_reg <= continuous;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        step_next      = step_reg;
        cfg_load       = 1'b0;
        cnt_load       = 1'b0;
        cnt_load_value = dwell_reg;
        cnt_dec        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start && !abort) begin
                    state_next     = RUN;
                    step_next      = f_start;
                    cfg_load       = 1'b1;
                    cnt_load       = 1'b1;
                    cnt_load_value = dwell;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (!sweep_end) begin
                    step_next = step_saturate ? f_stop_reg : step_sum[STEP_SIZE-1:0];
                    cnt_load  = 1'b1;
                end else if (continuous_reg) begin
                    // Restart immediately with no gap cycle.
                    step_next = f_start_reg;
                    cnt_load  = 1'b1;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign step = step_reg;
    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed testbench for nco_sweep_ctrl with hand-computed expected sequences.
module tb_nco_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        continuous = 1'b0;
    logic [15:0] f_start = '0;
    logic [15:0] f_stop = '0;
    logic [15:0] f_inc = '0;
    logic [15:0] dwell = '0;
    logic [15:0] step;
    logic        busy;
    logic        done;

    int tests_run = 0;
    int tests_failed = 0;

    nco_sweep_ctrl #(
        .STEP_SIZE   (16),
        .DWELL_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .continuous (continuous),
        .f_start    (f_start),
        .f_stop     (f_stop),
        .f_inc      (f_inc),
        .dwell      (dwell),
        .step       (step),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] fs, input logic [15:0] fp, input logic [15:0] fi,
                            input logic [15:0] dw, input logic cont);
        f_start    = fs;
        f_stop     = fp;
        f_inc      = fi;
        dwell      = dw;
        continuous = cont;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        $display("[TB] start f_start=%0d f_stop=%0d f_inc=%0d dwell=%0d cont=%0b", fs, fp, fi, dw, cont);
    endtask

    // Check that step==value with busy=1, done=0 for n consecutive cycles.
    task automatic check_hold(input string tag, input logic [15:0] value, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_step"}, 32'(step), 32'(value));
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_done"}, 32'(done), 32'd0);
            tick();
        end
        $display("[TB] %s: step %0d held %0d cycles", tag, value, n);
    endtask

    // Current cycle is the done pulse, and the next cycle is idle. Step is frozen.
    task automatic check_done(input string tag, input logic [15:0] final_step);
        check({tag, "_done_pulse"}, 32'(done), 32'd1);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_step"}, 32'(step), 32'(final_step));
        tick();
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_step"}, 32'(step), 32'(final_step));
        $display("[TB] %s: done, final step %0d", tag, final_step);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("reset_step", 32'(step), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        $display("[TB] reset state checked");
        rst = 1'b0;
        tick();
        check("post_reset_busy", 32'(busy), 32'd0);

        // Basic single sweep: 100,110,120,130 each for 3 cycles
        do_start(16'd100, 16'd130, 16'd10, 16'd2, 1'b0);
        check_hold("basic_100", 16'd100, 3);
        check_hold("basic_110", 16'd110, 3);
        check_hold("basic_120", 16'd120, 3);
        check_hold("basic_130", 16'd130, 3);
        check_done("basic", 16'd130);
        tick();
        check("basic_idle_hold_step", 32'(step), 32'd130);

        // Saturation to f_stop
        do_start(16'd100, 16'd125, 16'd10, 16'd0, 1'b0);
        check_hold("sat_100", 16'd100, 1);
        check_hold("sat_110", 16'd110, 1);
        check_hold("sat_120", 16'd120, 1);
        check_hold("sat_125", 16'd125, 1);
        check_done("sat", 16'd125);

        // Carry saturation, no wrap
        do_start(16'hFFF0, 16'hFFFF, 16'h0020, 16'd0, 1'b0);
        check_hold("carry_fff0", 16'hFFF0, 1);
        check_hold("carry_ffff", 16'hFFFF, 1);
        check_done("carry", 16'hFFFF);

        // Continuous: 0,0,10,10,20,20,0,0,10,10 then abort
        do_start(16'd0, 16'd20, 16'd10, 16'd1, 1'b1);
        check_hold("cont_0a", 16'd0, 2);
        check_hold("cont_10a", 16'd10, 2);
        check_hold("cont_20a", 16'd20, 2);
        check_hold("cont_0b", 16'd0, 2);
        check_hold("cont_10b", 16'd10, 1);
        check("cont_10b_last_step", 32'(step), 32'd10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_step", 32'(step), 32'd10);
        tick();
        check("abort_idle_step", 32'(step), 32'd10);
        check("abort_idle_done", 32'(done), 32'd0);
        $display("[TB] continuous sweep aborted, step frozen at 10");

        // Degenerate: zero increment
        do_start(16'd50, 16'd60, 16'd0, 16'd3, 1'b0);
        check_hold("inc0_50", 16'd50, 4);
        check_done("inc0", 16'd50);

        // Degenerate: f_start >= f_stop
        do_start(16'd200, 16'd100, 16'd10, 16'd3, 1'b0);
        check_hold("inv_200", 16'd200, 4);
        check_done("inv", 16'd200);

        // Start while busy plus config change mid-sweep: no effect
        do_start(16'd100, 16'd130, 16'd10, 16'd2, 1'b0);
        check_hold("busy_100a", 16'd100, 1);
        start      = 1'b1;
        f_start    = 16'd500;
        f_stop     = 16'd50;
        f_inc      = 16'd1;
        dwell      = 16'd7;
        continuous = 1'b1;
        check_hold("busy_100b", 16'd100, 2);
        start = 1'b0;
        check_hold("busy_110", 16'd110, 3);
        check_hold("busy_120", 16'd120, 3);
        check_hold("busy_130", 16'd130, 3);
        check_done("busy", 16'd130);

        // Start and abort together in IDLE: stays idle
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'd0);
        check("start_abort_step", 32'(step), 32'd130);
        tick();
        check("start_abort_busy2", 32'(busy), 32'd0);
        check("start_abort_done2", 32'(done), 32'd0);
        $display("[TB] start+abort in idle ignored");

        // Async reset mid-sweep, between clock edges
        do_start(16'd100, 16'd130, 16'd10, 16'd2, 1'b0);
        check_hold("rst_100", 16'd100, 3);
        check("rst_pre_step", 32'(step), 32'd110);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_step", 32'(step), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        $display("[TB] async reset mid-sweep applied");
        tick();
        rst = 1'b0;
        tick();
        do_start(16'd10, 16'd30, 16'd10, 16'd0, 1'b0);
        check_hold("after_rst_10", 16'd10, 1);
        check_hold("after_rst_20", 16'd20, 1);
        check_hold("after_rst_30", 16'd30, 1);
        check_done("after_rst", 16'd30);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
